pipe_event_monitor: RTL and testbench
=====================================

Name: pipe_event_monitor

Overview:
- Hardware performance and trace unit that sits directly downstream of the 5-stage pipeline CPU inside comp.
- Consumes the pipeline hazard/control status signals: stall, branch_taken, branch_target, forwardA/B, flush_IFID, flush_IDEX.
- Accumulates event counters and buffers taken-branch targets in a small trace FIFO.
- Exposes counters through a select/read port (same style as reg_sel/reg_data) and the FIFO through a valid/ready pop interface. Software and benches read pipeline statistics without hierarchical peeking.

Parameters:
- CNT_W, 32, width of every event counter.
- FIFO_DEPTH, 8, trace FIFO entries; must be a power of 2, >= 2.
- ADDR_W, 32, width of branch_target and trace_data.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  counting/trace enable; events ignored when 0.
- clr  input  1  synchronous clear of counters and FIFO.
- stall  input  1  pipeline stall this cycle.
- branch_taken  input  1  branch/jump resolved taken this cycle.
- branch_target  input  ADDR_W  target of the taken branch.
- forwardA  input  2  forwarding select, operand A.
- forwardB  input  2  forwarding select, operand B.
- flush_IFID  input  1  IF/ID flush.
- flush_IDEX  input  1  ID/EX flush.
- cnt_sel  input  3  counter read select.
- cnt_data  output  CNT_W  selected counter value (combinational).
- trace_valid  output  1  FIFO non-empty.
- trace_data  output  ADDR_W  FIFO head entry.
- trace_ready  input  1  consumer accepts the head entry.

Behaviour:
- Reset (rstn=0, asynchronous): all counters = 0; FIFO empty with rd/wr pointers = 0.
  - Resulting outputs: trace_valid = 0, trace_data = 0, cnt_data = 0 for every cnt_sel.
  - A reset mid-operation discards FIFO contents immediately.
- All state updates occur on rising clk. Inputs are sampled at that edge.
- Counters, each CNT_W wide, wrapping modulo 2^CNT_W with no saturation:
  - cyc_cnt: +1 every cycle with en=1.
  - stall_cnt: +1 when en & stall.
  - br_cnt: +1 when en & branch_taken.
  - fwd_cnt: +1 when en & (forwardA!=0 | forwardB!=0). Maximum of 1 per cycle, even if both are nonzero.
  - flush_cnt: +1 when en & (flush_IFID | flush_IDEX). Maximum of 1 per cycle.
  - drop_cnt: +1 when a trace push is discarded because the FIFO is full.
- clr has priority over all increments and over push/pop.
  - Next cycle: counters = 0 and FIFO is empty.
  - Events in the clr cycle are not counted.
- cnt_sel map, combinational, zero latency:
  - 0 cyc_cnt; 1 stall_cnt; 2 br_cnt; 3 fwd_cnt; 4 flush_cnt.
  - 5 FIFO occupancy, zero-extended.
  - 6 drop_cnt.
  - 7 constant 0.
- Trace FIFO:
  - Push request = en & branch_taken; pushes branch_target.
  - Pop = trace_valid & trace_ready.
  - trace_valid = (occupancy != 0). trace_data = mem[rd_ptr] when valid, else 0.
  - No bypass: a push into an empty FIFO makes trace_valid = 1 on the following cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
  - Full, push, no pop: entry dropped, drop_cnt +1, occupancy unchanged.
  - Full, push and pop in the same cycle: both succeed, occupancy stays FIFO_DEPTH, no drop.
  - Empty, pop requested: ignored, since trace_valid = 0.
  - Push and pop with 0 < occupancy < FIFO_DEPTH: both succeed, occupancy unchanged.
- trace_data and trace_valid must be held stable while trace_valid=1 & trace_ready=0.
- en=0 freezes all counters and blocks pushes. Pops still proceed.

Test Plan:
- Reset then en=1 for 10 cycles, stall high in cycles 3-5 -> cnt_sel=0 reads 10, cnt_sel=1 reads 3, all other selects read 0.
- forwardA=01 and forwardB=10 in the same cycle, plus flush_IFID=1 and flush_IDEX=1 in another cycle -> fwd_cnt=1, flush_cnt=1.
- 9 taken branches with targets 0x100..0x900 and trace_ready=0 -> occupancy=8, drop_cnt=1.
  - Then trace_ready=1 -> pops 0x100..0x800 in order, trace_valid drops after the 8th pop.
- FIFO full, push 0xA00 with trace_ready=1 in the same cycle -> head 0x100 popped, 0xA00 enqueued, occupancy stays 8, drop_cnt unchanged.
- Preload cyc_cnt to wrap (force 0xFFFFFFFF) and run 1 en cycle -> reads 0x00000000.
  - Then clr=1 with stall=1 -> all counters 0, stall not counted.
- Assert rstn=0 asynchronously between edges with 3 FIFO entries -> trace_valid=0 and all cnt_data=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/pipe_event_monitor.sv
// pipe_event_monitor: pipeline event counters plus taken-branch trace FIFO.
//
// Ports:
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   en                 enables counting and trace pushes (pops always allowed)
//   clr                synchronous clear of all counters and the FIFO
//   stall, branch_taken, branch_target, forwardA, forwardB,
//   flush_IFID, flush_IDEX       pipeline status sampled every cycle
//   cnt_sel / cnt_data combinational counter read port
//                      0 cyc, 1 stall, 2 branch, 3 forward, 4 flush,
//                      5 FIFO occupancy, 6 dropped pushes, 7 zero
//   trace_valid, trace_data, trace_ready   valid/ready pop side of the FIFO
module pipe_event_monitor #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    input  logic              flush_IFID,
    input  logic              flush_IDEX,
    input  logic [2:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_data,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_data,
    input  logic              trace_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CNT_W-1:0]  cyc_cnt, stall_cnt, br_cnt, fwd_cnt, flush_cnt, drop_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       occ;
    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic              push_req, full, pop, push, drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req = en & branch_taken;
    assign full     = occ == (PW+1)'(FIFO_DEPTH);
    assign pop      = trace_valid & trace_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            br_cnt    <= '0;
            fwd_cnt   <= '0;
            flush_cnt <= '0;
            drop_cnt  <= '0;
        end else if (clr) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            br_cnt    <= '0;
            fwd_cnt   <= '0;
            flush_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            cyc_cnt   <= cyc_cnt   + CNT_W'(en);
            stall_cnt <= stall_cnt + CNT_W'(en & stall);
            br_cnt    <= br_cnt    + CNT_W'(push_req);
            fwd_cnt   <= fwd_cnt   + CNT_W'(en & ((|forwardA) | (|forwardB)));
            flush_cnt <= flush_cnt + CNT_W'(en & (flush_IFID | flush_IDEX));
            drop_cnt  <= drop_cnt  + CNT_W'(drop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            occ    <= occ + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Storage needs no reset: trace_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= branch_target;
    end

    assign trace_valid = occ != '0;
    assign trace_data  = trace_valid ? mem[rd_ptr] : '0;

    always_comb begin
        cnt_data = '0;
        case (cnt_sel)
            3'd0:    cnt_data = cyc_cnt;
            3'd1:    cnt_data = stall_cnt;
            3'd2:    cnt_data = br_cnt;
            3'd3:    cnt_data = fwd_cnt;
            3'd4:    cnt_data = flush_cnt;
            3'd5:    cnt_data = CNT_W'(occ);
            3'd6:    cnt_data = drop_cnt;
            default: cnt_data = '0;
        endcase
    end
endmodule

// File: tb/tb_pipe_event_monitor.sv
// tb_pipe_event_monitor: directed self-checking bench for pipe_event_monitor.
`timescale 1ns/1ps
module tb_pipe_event_monitor;
    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, clr = 1'b0, stall = 1'b0;
    logic        branch_taken = 1'b0, flush_IFID = 1'b0, flush_IDEX = 1'b0, trace_ready = 1'b0;
    logic [31:0] branch_target = '0;
    logic [1:0]  forwardA = '0, forwardB = '0;
    logic [2:0]  cnt_sel = '0;
    logic [31:0] cnt_data;
    logic        trace_valid;
    logic [31:0] trace_data;

    logic        en2 = 1'b0, clr2 = 1'b0, stall2 = 1'b0;
    logic [2:0]  sel2 = '0;
    logic [3:0]  cnt2;
    logic        tv2;
    logic [31:0] td2;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    pipe_event_monitor dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .forwardA(forwardA), .forwardB(forwardB),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .cnt_sel(cnt_sel), .cnt_data(cnt_data),
        .trace_valid(trace_valid), .trace_data(trace_data), .trace_ready(trace_ready)
    );

    // Narrow counters so wrap-around is reachable in a few cycles.
    pipe_event_monitor #(.CNT_W(4)) dut_w (
        .clk(clk), .rstn(rstn), .en(en2), .clr(clr2), .stall(stall2),
        .branch_taken(1'b0), .branch_target(32'h0),
        .forwardA(2'b00), .forwardB(2'b00),
        .flush_IFID(1'b0), .flush_IDEX(1'b0),
        .cnt_sel(sel2), .cnt_data(cnt2),
        .trace_valid(tv2), .trace_data(td2), .trace_ready(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] s, input logic [31:0] exp, input string tag);
        cnt_sel = s;
        #1;
        chk(tag, {32'h0, cnt_data}, {32'h0, exp});
    endtask

    task automatic rd2(input logic [2:0] s, input logic [3:0] exp, input string tag);
        sel2 = s;
        #1;
        chk(tag, {60'h0, cnt2}, {60'h0, exp});
    endtask

    logic [31:0] exp_q [8];

    initial begin
        // reset state
        tick();
        for (int s = 0; s < 8; s++) rd(3'(s), 32'h0, "reset_cnt");
        chk("reset_valid", {63'h0, trace_valid}, 64'h0);
        chk("reset_data", {32'h0, trace_data}, 64'h0);
        rstn = 1'b1;
        tick();

        // 10 enabled cycles, stall in cycles 3..5
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            stall = (i >= 3 && i <= 5);
            tick();
        end
        en = 1'b0; stall = 1'b0;
        rd(0, 32'd10, "cyc10");
        rd(1, 32'd3, "stall3");
        for (int s = 2; s < 8; s++) rd(3'(s), 32'h0, "others0");

        // forwarding both operands in one cycle, both flushes in another
        en = 1'b1; forwardA = 2'b01; forwardB = 2'b10;
        tick();
        forwardA = 2'b00; forwardB = 2'b00; flush_IFID = 1'b1; flush_IDEX = 1'b1;
        tick();
        flush_IFID = 1'b0; flush_IDEX = 1'b0;
        en = 1'b0; stall = 1'b1; forwardA = 2'b11;
        tick();
        stall = 1'b0; forwardA = 2'b00;
        rd(3, 32'd1, "fwd1");
        rd(4, 32'd1, "flush1");
        rd(0, 32'd12, "cyc12");
        rd(1, 32'd3, "stall_frozen");

        // 9 taken branches, consumer not ready: one drop
        en = 1'b1; branch_taken = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            branch_target = 32'(k) * 32'h100;
            tick();
        end
        en = 1'b0; branch_taken = 1'b0;
        rd(5, 32'd8, "occ_full");
        rd(6, 32'd1, "drop1");
        rd(2, 32'd9, "br9");
        rd(0, 32'd21, "cyc21");
        tick();
        chk("hold_valid", {63'h0, trace_valid}, 64'h1);
        chk("hold_data", {32'h0, trace_data}, 64'h100);

        // drain in order
        trace_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", {63'h0, trace_valid}, 64'h1);
            chk("drain_data", {32'h0, trace_data}, 64'(k) * 64'h100);
            tick();
        end
        chk("empty_valid", {63'h0, trace_valid}, 64'h0);
        chk("empty_data", {32'h0, trace_data}, 64'h0);
        tick();
        rd(5, 32'd0, "pop_empty_occ");
        trace_ready = 1'b0;

        // refill, then push+pop while full
        en = 1'b1; branch_taken = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            branch_target = 32'(k) * 32'h100;
            tick();
        end
        branch_target = 32'hA00; trace_ready = 1'b1;
        tick();
        en = 1'b0; branch_taken = 1'b0; trace_ready = 1'b0;
        rd(5, 32'd8, "full_pp_occ");
        rd(6, 32'd1, "full_pp_drop");
        rd(2, 32'd18, "br18");
        rd(0, 32'd30, "cyc30");
        chk("full_pp_head", {32'h0, trace_data}, 64'h200);

        exp_q = '{32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800, 32'hA00};
        trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain2_data", {32'h0, trace_data}, {32'h0, exp_q[k]});
            tick();
        end
        chk("drain2_empty", {63'h0, trace_valid}, 64'h0);
        trace_ready = 1'b0;

        // clear with events in the same cycle
        en = 1'b1; branch_taken = 1'b1; branch_target = 32'hB00;
        tick();
        branch_target = 32'hC00;
        tick();
        rd(5, 32'd2, "pre_clr_occ");
        clr = 1'b1; stall = 1'b1; branch_target = 32'hC40;
        tick();
        clr = 1'b0; en = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        for (int s = 0; s < 8; s++) rd(3'(s), 32'h0, "clr_cnt");
        chk("clr_valid", {63'h0, trace_valid}, 64'h0);
        en = 1'b1; stall = 1'b1;
        tick();
        en = 1'b0; stall = 1'b0;
        rd(1, 32'd1, "post_clr_stall");
        rd(0, 32'd1, "post_clr_cyc");

        // counter wrap on the narrow instance
        en2 = 1'b1;
        repeat (15) tick();
        rd2(0, 4'hF, "wrap_pre");
        stall2 = 1'b1;
        tick();
        stall2 = 1'b0;
        rd2(0, 4'h0, "wrap_zero");
        rd2(1, 4'h1, "wrap_stall1");
        clr2 = 1'b1; stall2 = 1'b1;
        tick();
        clr2 = 1'b0; stall2 = 1'b0; en2 = 1'b0;
        rd2(0, 4'h0, "wrap_clr_cyc");
        rd2(1, 4'h0, "wrap_clr_stall");

        // asynchronous reset with 3 entries queued
        en = 1'b1; branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            branch_target = 32'hD00 + 32'(k) * 32'h100;
            tick();
        end
        en = 1'b0; branch_taken = 1'b0;
        rd(5, 32'd3, "pre_rst_occ");
        chk("pre_rst_valid", {63'h0, trace_valid}, 64'h1);
        cnt_sel = 3'd0;
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {63'h0, trace_valid}, 64'h0);
        chk("arst_data", {32'h0, trace_data}, 64'h0);
        for (int s = 0; s < 8; s++) rd(3'(s), 32'h0, "arst_cnt");
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_valid", {63'h0, trace_valid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
